// File: rtl/host_req_queue.sv
// Host request FIFO feeding the AXI-Lite master, plus a held read-response register.
// Optional HOST_REQ_QUEUE_BYPASS_EN presents an enqueue into an empty queue in the same cycle.
module host_req_queue #(
  parameter int unsigned HOST_ADDR_BITS = 8,
  parameter int unsigned HOST_DATA_BITS = 32,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned CNT_BITS       = $clog2(DEPTH) + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic                      enq_opcode,
  input  logic [HOST_ADDR_BITS-1:0] enq_addr,
  input  logic [HOST_DATA_BITS-1:0] enq_value,
  output logic                      host_req_valid,
  output logic                      host_req_opcode,
  output logic [HOST_ADDR_BITS-1:0] host_req_addr,
  output logic [HOST_DATA_BITS-1:0] host_req_value,
  input  logic                      host_req_deq,
  input  logic                      host_resp_valid,
  input  logic [HOST_DATA_BITS-1:0] host_resp_bits,
  output logic                      resp_valid,
  output logic [HOST_DATA_BITS-1:0] resp_bits,
  input  logic                      resp_ack,
  output logic                      resp_overflow,
  output logic [CNT_BITS-1:0]       count
);

  localparam int unsigned IDX_BITS = $clog2(DEPTH);

  typedef struct packed {
    logic                      opcode;
    logic [HOST_ADDR_BITS-1:0] addr;
    logic [HOST_DATA_BITS-1:0] value;
  } entry_t;

  entry_t              mem [DEPTH];
  entry_t              head;
  logic [CNT_BITS-1:0] wr_ptr;
  logic [CNT_BITS-1:0] rd_ptr;
  logic [CNT_BITS-1:0] count_next;
  logic                enq_fire;
  logic                deq_fire;
  logic                do_write;
  logic                do_pop;
  logic                empty;

  assign empty     = (count == '0);
  assign enq_ready = (count != CNT_BITS'(DEPTH));
  assign head      = mem[rd_ptr[IDX_BITS-1:0]];
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = host_req_deq & host_req_valid;

`ifdef HOST_REQ_QUEUE_BYPASS_EN
  // Empty queue: the offered request is the head; consumed in flight it is never stored.
  logic bypass_fire;
  assign host_req_valid  = empty ? enq_valid : 1'b1;
  assign host_req_opcode = empty ? enq_opcode : head.opcode;
  assign host_req_addr   = empty ? enq_addr : head.addr;
  assign host_req_value  = empty ? enq_value : head.value;
  assign bypass_fire     = empty & enq_fire & deq_fire;
  assign do_write        = enq_fire & ~bypass_fire;
  assign do_pop          = deq_fire & ~bypass_fire;
`else
  assign host_req_valid  = ~empty;
  assign host_req_opcode = head.opcode;
  assign host_req_addr   = head.addr;
  assign host_req_value  = head.value;
  assign do_write        = enq_fire;
  assign do_pop          = deq_fire;
`endif

  // Occupancy next-state
  always_comb begin
    count_next = count;
    if (do_write && !do_pop) begin
      count_next = count + CNT_BITS'(1);
    end else if (do_pop && !do_write) begin
      count_next = count - CNT_BITS'(1);
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + CNT_BITS'(1);
      if (do_pop)   rd_ptr <= rd_ptr + CNT_BITS'(1);
      count <= count_next;
    end
  end

  // Entry storage; cleared on reset so the head fields read zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[wr_ptr[IDX_BITS-1:0]] <= '{opcode: enq_opcode, addr: enq_addr, value: enq_value};
    end
  end

  // Held read response; a new pulse replaces it only if the slot is free or freed this cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_valid    <= 1'b0;
      resp_bits     <= '0;
      resp_overflow <= 1'b0;
    end else if (host_resp_valid) begin
      if (!resp_valid || resp_ack) begin
        resp_bits  <= host_resp_bits;
        resp_valid <= 1'b1;
      end else begin
        resp_overflow <= 1'b1;
      end
    end else if (resp_ack && resp_valid) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_host_req_queue.sv
// Self-checking bench for host_req_queue: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_host_req_queue;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic          enq_valid, enq_ready, enq_opcode;
  logic [AW-1:0] enq_addr;
  logic [DW-1:0] enq_value;
  logic          host_req_valid, host_req_opcode;
  logic [AW-1:0] host_req_addr;
  logic [DW-1:0] host_req_value;
  logic          host_req_deq;
  logic          host_resp_valid;
  logic [DW-1:0] host_resp_bits;
  logic          resp_valid;
  logic [DW-1:0] resp_bits;
  logic          resp_ack;
  logic          resp_overflow;
  logic [CW-1:0] count;

  host_req_queue #(.HOST_ADDR_BITS(AW), .HOST_DATA_BITS(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_opcode(enq_opcode),
    .enq_addr(enq_addr), .enq_value(enq_value),
    .host_req_valid(host_req_valid), .host_req_opcode(host_req_opcode),
    .host_req_addr(host_req_addr), .host_req_value(host_req_value),
    .host_req_deq(host_req_deq),
    .host_resp_valid(host_resp_valid), .host_resp_bits(host_resp_bits),
    .resp_valid(resp_valid), .resp_bits(resp_bits), .resp_ack(resp_ack),
    .resp_overflow(resp_overflow), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          op;
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
  } ent_t;

  ent_t          mq[$];
  logic          m_rv, m_ov;
  logic [DW-1:0] m_rb;
  int            checks = 0;
  int            errors = 0;
  bit            byp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    bit   exp_v;
    ent_t h;
    exp_v = (mq.size() != 0) || (byp && enq_valid);
    chk("count", 64'(count), 64'(mq.size()));
    chk("enq_ready", 64'(enq_ready), 64'(mq.size() != DEPTH));
    chk("req_valid", 64'(host_req_valid), 64'(exp_v));
    if (exp_v) begin
      if (mq.size() != 0) h = mq[0];
      else h = '{enq_opcode, enq_addr, enq_value};
      chk("req_opcode", 64'(host_req_opcode), 64'(h.op));
      chk("req_addr", 64'(host_req_addr), 64'(h.addr));
      chk("req_value", 64'(host_req_value), 64'(h.val));
    end
    chk("resp_valid", 64'(resp_valid), 64'(m_rv));
    chk("resp_bits", 64'(resp_bits), 64'(m_rb));
    chk("resp_overflow", 64'(resp_overflow), 64'(m_ov));
  endtask

  // One clock: predict from current inputs, clock the DUT, update model, compare.
  task automatic step();
    int   n;
    bit   enq_ok, head_v, deq_ok;
    ent_t e;
    n      = mq.size();
    enq_ok = enq_valid && (n < DEPTH);
    head_v = (n != 0) || (byp && enq_valid);
    deq_ok = host_req_deq && head_v;
    e      = '{enq_opcode, enq_addr, enq_value};
    if (host_resp_valid) begin
      if (!m_rv || resp_ack) begin
        m_rb = host_resp_bits;
        m_rv = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else if (resp_ack && m_rv) begin
      m_rv = 1'b0;
    end
    @(posedge clock);
    #1;
    if (!(byp && n == 0 && enq_ok && deq_ok)) begin
      if (deq_ok && n != 0) void'(mq.pop_front());
      if (enq_ok) mq.push_back(e);
    end
    check_all();
  endtask

  task automatic set_enq(input logic v, input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    enq_valid = v; enq_opcode = op; enq_addr = a; enq_value = d;
  endtask

  task automatic idle();
    set_enq(1'b0, 1'b0, '0, '0);
    host_req_deq = 1'b0; host_resp_valid = 1'b0; host_resp_bits = '0; resp_ack = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_rv = 1'b0; m_rb = '0; m_ov = 1'b0;
  endtask

  initial begin
`ifdef HOST_REQ_QUEUE_BYPASS_EN
    byp = 1'b1;
`endif
    idle();
    model_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    // Reset state with no stimulus
    chk("rst_req_valid", 64'(host_req_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_req_addr", 64'(host_req_addr), 64'd0);
    chk("rst_req_value", 64'(host_req_value), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_overflow", 64'(resp_overflow), 64'd0);
    step();

    // Write then read, head order and count 2->1->0
    set_enq(1'b1, 1'b1, 8'h08, 32'hDEADBEEF); step();
    chk("wr_head_addr", 64'(host_req_addr), 64'h08);
    chk("wr_head_value", 64'(host_req_value), 64'hDEADBEEF);
    set_enq(1'b1, 1'b0, 8'h10, 32'h0); step();
    chk("two_count", 64'(count), 64'd2);
    set_enq(1'b0, 1'b0, '0, '0); host_req_deq = 1'b1; step();
    chk("rd_head_op", 64'(host_req_opcode), 64'd0);
    chk("rd_head_addr", 64'(host_req_addr), 64'h10);
    step();
    chk("drained_count", 64'(count), 64'd0);
    host_req_deq = 1'b0;
    step();

    // Fill to full across the pointer wrap, refuse 5th, deq at full
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(1'b1, 1'(i), 8'(8'h20 + i), 32'(32'hA000 + i)); step();
    end
    chk("full_ready", 64'(enq_ready), 64'd0);
    set_enq(1'b1, 1'b1, 8'hEE, 32'hEEEE); step();
    chk("full_refuse_count", 64'(count), 64'd4);
    host_req_deq = 1'b1; step();
    chk("full_deq_enq_count", 64'(count), 64'd3);
    host_req_deq = 1'b0; step();
    chk("refill_count", 64'(count), 64'd4);
    set_enq(1'b0, 1'b0, '0, '0); host_req_deq = 1'b1;
    repeat (DEPTH + 1) step();
    host_req_deq = 1'b0;

    // Held response, ack, overflow, replace-on-ack
    host_resp_valid = 1'b1; host_resp_bits = 32'h2A; step();
    host_resp_valid = 1'b0; step();
    chk("resp_held", 64'(resp_bits), 64'h2A);
    resp_ack = 1'b1; step();
    chk("resp_acked", 64'(resp_valid), 64'd0);
    resp_ack = 1'b0; host_resp_valid = 1'b1; host_resp_bits = 32'h2A; step();
    host_resp_bits = 32'h55; step();
    chk("ovf_kept", 64'(resp_bits), 64'h2A);
    chk("ovf_flag", 64'(resp_overflow), 64'd1);
    resp_ack = 1'b1; step();
    chk("ack_replace", 64'(resp_bits), 64'h55);
    chk("ack_replace_v", 64'(resp_valid), 64'd1);
    idle(); step();

    // Async reset mid-traffic with queued entries and held response
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 1'b1, 8'(8'h40 + i), 32'(i + 7)); step();
    end
    idle();
    reset = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_req_valid", 64'(host_req_valid), 64'd0);
    chk("arst_req_addr", 64'(host_req_addr), 64'd0);
    chk("arst_enq_ready", 64'(enq_ready), 64'd1);
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_resp_bits", 64'(resp_bits), 64'd0);
    chk("arst_overflow", 64'(resp_overflow), 64'd0);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    step();

`ifdef HOST_REQ_QUEUE_BYPASS_EN
    set_enq(1'b1, 1'b1, 8'h77, 32'h1234);
    #1;
    chk("byp_valid", 64'(host_req_valid), 64'd1);
    chk("byp_addr", 64'(host_req_addr), 64'h77);
    host_req_deq = 1'b1; step();
    chk("byp_count", 64'(count), 64'd0);
    idle(); step();
`endif

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      set_enq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom));
      host_req_deq    = ($urandom_range(0, 2) == 0);
      host_resp_valid = ($urandom_range(0, 3) == 0);
      host_resp_bits  = 32'($urandom);
      resp_ack        = ($urandom_range(0, 2) == 0);
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_req_queue.md
Name: host_req_queue

Overview:
Buffering stage directly upstream of the host AXI-Lite master. It accepts host register read/write requests from the DPI host model into a FIFO and presents them on the host_req_* valid/deq interface. It also captures the single-cycle read-response pulse returned by the AXI master into a held register until the host model acknowledges it. Sits between the simulation host driver and the AXI-Lite control bridge.

Parameters:
HOST_ADDR_BITS, 8, request address width
HOST_DATA_BITS, 32, request/response data width
DEPTH, 4, FIFO entries; power of 2, >= 2
CNT_BITS, $clog2(DEPTH)+1, occupancy counter width

Ports:
clock  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low (asserted when 0)
enq_valid  in  1  host driver offers a request
enq_ready  out  1  queue can accept (not full)
enq_opcode  in  1  1=write, 0=read
enq_addr  in  HOST_ADDR_BITS  register address
enq_value  in  HOST_DATA_BITS  write data (ignored for reads)
host_req_valid  out  1  head entry present
host_req_opcode  out  1  head opcode
host_req_addr  out  HOST_ADDR_BITS  head address
host_req_value  out  HOST_DATA_BITS  head data
host_req_deq  in  1  consumer pops head this cycle
host_resp_valid  in  1  read-data pulse from AXI master
host_resp_bits  in  HOST_DATA_BITS  read data
resp_valid  out  1  held response available
resp_bits  out  HOST_DATA_BITS  held response data
resp_ack  in  1  host driver consumes held response
resp_overflow  out  1  sticky: response arrived while one was held
count  out  CNT_BITS  current FIFO occupancy

Behaviour:
- Reset (reset==0, async): pointers 0, count 0, enq_ready 1, host_req_valid 0, host_req_* data 0, resp_valid 0, resp_bits 0, resp_overflow 0. Reset mid-transfer discards all entries and held response immediately.
- Storage: DEPTH-entry array of {opcode, addr, value}; rd/wr pointers CNT_BITS wide, index = low bits, wrap naturally at DEPTH.
- Enqueue fires on enq_valid & enq_ready; enq_ready = (count != DEPTH), combinational from state only.
- Dequeue fires on host_req_deq & host_req_valid; deq while empty ignored, no pointer change.
- host_req_valid = (count != 0); host_req_* driven from array[rd_ptr] (registered storage; enqueue into empty queue visible next cycle, latency 1).
- Head stability: head fields must not change while host_req_valid=1 and no deq.
- Simultaneous enq and deq: both occur, count unchanged; legal when full (deq frees slot same cycle? no: enq_ready is 0 when full, enq refused that cycle).
- count: +1 on enq only, -1 on deq only, unchanged otherwise.
- Response: on host_resp_valid, if resp_valid==0 or resp_ack==1 same cycle -> resp_bits<=host_resp_bits, resp_valid<=1. Otherwise new data dropped, old held, resp_overflow<=1 (sticky until reset).
- resp_ack with resp_valid and no new response -> resp_valid<=0, resp_bits held. resp_ack when resp_valid==0 ignored.

Optional Feature:
HOST_REQ_QUEUE_BYPASS_EN: when defined, an enqueue into an empty queue is presented combinationally the same cycle (host_req_valid=enq_valid when count==0, fields from enq_*); if host_req_deq is also asserted that cycle, entry is not written and count stays 0; otherwise it is written normally. Without the macro, latency is strictly 1 cycle and host_req_* depend only on registered state.

Test Plan:
- Reset release, no stimulus -> host_req_valid 0, enq_ready 1, count 0, resp_valid 0, resp_overflow 0.
- Enq write {1,0x08,0xDEADBEEF} then read {0,0x10,x} -> head shows 0x08/0xDEADBEEF next cycle; after deq head shows opcode 0 addr 0x10; count 2->1->0.
- Enq 4 entries (DEPTH=4), deq held low -> enq_ready 0, 5th enq_valid refused; deq+enq_valid same cycle at full -> count 3; then enq -> 4; drain preserves order across pointer wrap.
- host_resp_valid pulse 0x0000002A -> resp_valid 1, resp_bits 0x2A held; resp_ack -> resp_valid 0 next cycle.
- Second pulse 0x55 while 0x2A held unacked -> resp_bits stays 0x2A, resp_overflow 1; pulse with resp_ack same cycle -> resp_bits 0x55, resp_valid 1.
- Assert reset with 3 entries queued and response held -> all outputs reset values immediately, no clock needed; with HOST_REQ_QUEUE_BYPASS_EN, enq into empty -> host_req_valid same cycle, with deq -> count stays 0.
